// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit: RV32 load/store funct3 codes,
// FSM state encoding and the native CPU data width.
package lsu_ctrl_pkg;

    localparam int CPU_WIDTH = 32;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_t;

    // Access size codes used by the formatter.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/lsu_fmt.sv
// Combinational access formatter: legality/alignment check, store lane
// replication and byte enables, and load lane extraction with extension.
module lsu_fmt
    import lsu_ctrl_pkg::*;
#(
    parameter int DATA_W = CPU_WIDTH
) (
    input  logic              i_is_load,
    input  logic [2:0]        i_funct3,
    input  logic [1:0]        i_off,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_err,
    output logic [3:0]        o_wmask,
    output logic [DATA_W-1:0] o_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] w_shift;
    logic              w_legal;
    logic              w_misal;
    logic [1:0]        w_size;

    assign w_shift = i_rdata >> {i_off, 3'b000};

    always_comb begin
        w_legal = 1'b0;
        w_size  = SZ_BYTE;
        o_rdata = '0;
        if (i_is_load) begin
            case (i_funct3)
                F3_LB: begin
                    w_legal = 1'b1;
                    w_size  = SZ_BYTE;
                    o_rdata = {{24{w_shift[7]}}, w_shift[7:0]};
                end
                F3_LH: begin
                    w_legal = 1'b1;
                    w_size  = SZ_HALF;
                    o_rdata = {{16{w_shift[15]}}, w_shift[15:0]};
                end
                F3_LW: begin
                    w_legal = 1'b1;
                    w_size  = SZ_WORD;
                    o_rdata = i_rdata;
                end
                F3_LBU: begin
                    w_legal = 1'b1;
                    w_size  = SZ_BYTE;
                    o_rdata = {24'd0, w_shift[7:0]};
                end
                F3_LHU: begin
                    w_legal = 1'b1;
                    w_size  = SZ_HALF;
                    o_rdata = {16'd0, w_shift[15:0]};
                end
                default: w_legal = 1'b0;
            endcase
        end else begin
            case (i_funct3)
                F3_SB:   begin w_legal = 1'b1; w_size = SZ_BYTE; end
                F3_SH:   begin w_legal = 1'b1; w_size = SZ_HALF; end
                F3_SW:   begin w_legal = 1'b1; w_size = SZ_WORD; end
                default: w_legal = 1'b0;
            endcase
        end
    end

    assign w_misal = ((w_size == SZ_HALF) && i_off[0]) ||
                     ((w_size == SZ_WORD) && (i_off != 2'b00));
    assign o_err   = !w_legal || w_misal;

    // Stores replicate the datum across all lanes; the mask picks the live lane.
    always_comb begin
        o_wmask = 4'b0000;
        o_wdata = '0;
        if (!i_is_load) begin
            case (w_size)
                SZ_BYTE: begin
                    o_wmask = 4'b0001 << i_off;
                    o_wdata = {4{i_wdata[7:0]}};
                end
                SZ_HALF: begin
                    o_wmask = 4'b0011 << i_off;
                    o_wdata = {2{i_wdata[15:0]}};
                end
                default: begin
                    o_wmask = 4'hF;
                    o_wdata = i_wdata;
                end
            endcase
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store unit: accepts one execute-stage request, runs a
// req/ack memory transaction and returns a one-cycle done pulse.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = CPU_WIDTH
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic              i_lden,
    input  logic              i_sten,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_ready,
    output logic              o_done,
    output logic              o_err,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [3:0]        o_mem_wmask,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    lsu_state_t        r_state;
    logic              r_is_load;
    logic [2:0]        r_funct3;
    logic [1:0]        r_off;
    logic              r_ready;
    logic              r_done;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [3:0]        r_mem_wmask;

    logic              w_idle;
    logic              w_accept;
    logic              w_sel_load;
    logic [2:0]        w_sel_funct3;
    logic [1:0]        w_sel_off;
    logic              w_fmt_err;
    logic [3:0]        w_fmt_wmask;
    logic [DATA_W-1:0] w_fmt_wdata;
    logic [DATA_W-1:0] w_fmt_rdata;

    assign w_idle   = (r_state == LSU_IDLE);
    assign w_accept = w_idle && i_valid && (i_lden ^ i_sten);

    // One formatter serves both phases: live request while idle, latched op afterwards.
    assign w_sel_load   = w_idle ? i_lden         : r_is_load;
    assign w_sel_funct3 = w_idle ? i_funct3       : r_funct3;
    assign w_sel_off    = w_idle ? i_addr[1:0]    : r_off;

    lsu_fmt #(
        .DATA_W (DATA_W)
    ) u_fmt (
        .i_is_load (w_sel_load),
        .i_funct3  (w_sel_funct3),
        .i_off     (w_sel_off),
        .i_wdata   (i_wdata),
        .i_rdata   (i_mem_rdata),
        .o_err     (w_fmt_err),
        .o_wmask   (w_fmt_wmask),
        .o_wdata   (w_fmt_wdata),
        .o_rdata   (w_fmt_rdata)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= LSU_IDLE;
            r_is_load   <= 1'b0;
            r_funct3    <= 3'd0;
            r_off       <= 2'd0;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wmask <= 4'b0000;
        end else begin
            case (r_state)
                LSU_IDLE: begin
                    if (w_accept) begin
                        r_is_load <= i_lden;
                        r_funct3  <= i_funct3;
                        r_off     <= i_addr[1:0];
                        r_ready   <= 1'b0;
                        if (w_fmt_err) begin
                            r_state <= LSU_RESP;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state     <= LSU_REQ;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= i_sten;
                            r_mem_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
                            r_mem_wdata <= w_fmt_wdata;
                            r_mem_wmask <= w_fmt_wmask;
                        end
                    end
                end
                LSU_REQ: begin
                    if (i_mem_ack) begin
                        r_state   <= LSU_RESP;
                        r_mem_req <= 1'b0;
                        r_done    <= 1'b1;
                        r_err     <= 1'b0;
                        if (r_is_load) begin
                            r_rdata <= w_fmt_rdata;
                        end
                    end
                end
                LSU_RESP: begin
                    r_state <= LSU_IDLE;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state   <= LSU_IDLE;
                    r_done    <= 1'b0;
                    r_err     <= 1'b0;
                    r_ready   <= 1'b1;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready     = r_ready;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_rdata     = r_rdata;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_wmask = r_mem_wmask;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases plus random accesses,
// each compared against an arithmetic reference model of the access rules.
module tb_lsu_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        i_lden;
    logic        i_sten;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_ready;
    logic        o_done;
    logic        o_err;
    logic [31:0] o_rdata;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wmask;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    int          n_vec = 0;
    int          n_miss = 0;
    logic [31:0] last_rdata = 32'd0;

    lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .i_lden      (i_lden),
        .i_sten      (i_sten),
        .i_funct3    (i_funct3),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_ready     (o_ready),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_rdata     (o_rdata),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_wmask (o_mem_wmask),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes, alignment by modulo, lane data by arithmetic.
    function automatic void model(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] mw,
                                  output bit err, output logic [3:0] wm,
                                  output logic [31:0] wdo, output logic [31:0] rd);
        int     nbytes;
        int     o;
        bit     legal;
        bit     sgn;
        longint v;
        longint span;
        nbytes = 1;
        legal  = 1'b0;
        sgn    = 1'b0;
        o      = int'(a % 4);
        if (ld) begin
            case (f3)
                3'd0: begin legal = 1'b1; nbytes = 1; sgn = 1'b1; end
                3'd1: begin legal = 1'b1; nbytes = 2; sgn = 1'b1; end
                3'd2: begin legal = 1'b1; nbytes = 4; end
                3'd4: begin legal = 1'b1; nbytes = 1; end
                3'd5: begin legal = 1'b1; nbytes = 2; end
                default: legal = 1'b0;
            endcase
        end else if (f3 <= 3'd2) begin
            legal  = 1'b1;
            nbytes = 1 << f3;
        end
        err = !legal || ((a % nbytes) != 0);
        wm  = 4'd0;
        wdo = 32'd0;
        rd  = 32'd0;
        if (!ld) begin
            wm = 4'(((1 << nbytes) - 1) << o);
            case (nbytes)
                1:       wdo = wd[7:0] * 32'h01010101;
                2:       wdo = wd[15:0] * 32'h00010001;
                default: wdo = wd;
            endcase
        end else begin
            span = 64'd1 << (8 * nbytes);
            v    = longint'(mw >> (8 * o)) % span;
            if (sgn && v >= (span / 2)) v = v - span;
            rd = 32'(v);
        end
    endfunction

    task automatic run_op(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] mw, input int waits);
        bit          e;
        logic [3:0]  wm;
        logic [31:0] wdo;
        logic [31:0] rd;
        model(ld, f3, a, wd, mw, e, wm, wdo, rd);
        chk("ready_before", o_ready, 32'd1);
        i_valid  = 1'b1;
        i_lden   = ld;
        i_sten   = !ld;
        i_funct3 = f3;
        i_addr   = a;
        i_wdata  = wd;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_lden  = 1'b0;
        i_sten  = 1'b0;
        i_wdata = $urandom;
        if (e) begin
            chk("err_done_c1", o_done, 32'd1);
            chk("err_flag", o_err, 32'd1);
            chk("err_no_req", o_mem_req, 32'd0);
            chk("err_rdata_hold", o_rdata, last_rdata);
        end else begin
            for (int c = 0; c <= waits; c++) begin
                chk("req_held", o_mem_req, 32'd1);
                chk("no_early_done", o_done, 32'd0);
                chk("mem_we", o_mem_we, {31'd0, !ld});
                chk("mem_addr", o_mem_addr, a & 32'hFFFFFFFC);
                chk("mem_wmask", o_mem_wmask, wm);
                if (!ld) chk("mem_wdata", o_mem_wdata, wdo);
                if (c == waits) begin
                    i_mem_ack   = 1'b1;
                    i_mem_rdata = mw;
                end
                @(posedge i_clk); #1;
                i_mem_ack   = 1'b0;
                i_mem_rdata = $urandom;
            end
            chk("done_after_ack", o_done, 32'd1);
            chk("no_err", o_err, 32'd0);
            chk("req_dropped", o_mem_req, 32'd0);
            if (ld) last_rdata = rd;
            chk("rdata", o_rdata, last_rdata);
        end
        $display("op ld=%0d f3=%0d addr=%h wdata=%h memword=%h waits=%0d -> err=%0d rdata=%h",
                 ld, f3, a, wd, mw, waits, e, o_rdata);
        @(posedge i_clk); #1;
        chk("done_one_cycle", o_done, 32'd0);
        chk("ready_after", o_ready, 32'd1);
    endtask

    initial begin
        i_rst       = 1'b1;
        i_valid     = 1'b0;
        i_lden      = 1'b0;
        i_sten      = 1'b0;
        i_funct3    = 3'd0;
        i_addr      = 32'd0;
        i_wdata     = 32'd0;
        i_mem_ack   = 1'b0;
        i_mem_rdata = 32'd0;
        @(posedge i_clk); @(posedge i_clk); #1;
        chk("rst_ready", o_ready, 32'd1);
        chk("rst_done", o_done, 32'd0);
        chk("rst_err", o_err, 32'd0);
        chk("rst_req", o_mem_req, 32'd0);
        chk("rst_we", o_mem_we, 32'd0);
        chk("rst_rdata", o_rdata, 32'd0);
        chk("rst_addr", o_mem_addr, 32'd0);
        chk("rst_wdata", o_mem_wdata, 32'd0);
        chk("rst_wmask", o_mem_wmask, 32'd0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        run_op(1'b0, 3'd2, 32'h80000010, 32'hDEADBEEF, 32'h0, 2);
        run_op(1'b0, 3'd0, 32'h80000013, 32'h000000A5, 32'h0, 0);
        run_op(1'b1, 3'd0, 32'h80000021, 32'h0, 32'h1234F678, 1);
        run_op(1'b1, 3'd4, 32'h80000021, 32'h0, 32'h1234F678, 0);
        run_op(1'b1, 3'd1, 32'h80000021, 32'h0, 32'h1234F678, 0);
        run_op(1'b1, 3'd5, 32'h80000022, 32'h0, 32'h8001ABCD, 0);
        run_op(1'b1, 3'd1, 32'h80000022, 32'h0, 32'h8001ABCD, 3);
        run_op(1'b1, 3'd2, 32'h80000022, 32'h0, 32'h8001ABCD, 0);
        run_op(1'b1, 3'd3, 32'h80000020, 32'h0, 32'h0, 0);
        run_op(1'b0, 3'd1, 32'h80000032, 32'h0000C3D4, 32'h0, 1);

        // Both or neither op bits, plus stray acks, must leave the unit idle.
        for (int c = 0; c < 4; c++) begin
            i_valid   = 1'b1;
            i_lden    = (c < 2);
            i_sten    = (c < 2);
            i_mem_ack = 1'b1;
            @(posedge i_clk); #1;
            chk("ign_ready", o_ready, 32'd1);
            chk("ign_done", o_done, 32'd0);
            chk("ign_req", o_mem_req, 32'd0);
        end
        i_valid   = 1'b0;
        i_mem_ack = 1'b0;

        // Asynchronous reset in the middle of a pending request.
        i_valid  = 1'b1;
        i_lden   = 1'b1;
        i_sten   = 1'b0;
        i_funct3 = 3'd2;
        i_addr   = 32'h80000040;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_lden  = 1'b0;
        chk("pre_rst_req", o_mem_req, 32'd1);
        #3 i_rst = 1'b1;
        #1;
        chk("async_req_drop", o_mem_req, 32'd0);
        chk("async_ready", o_ready, 32'd1);
        @(posedge i_clk); #1;
        i_rst       = 1'b0;
        last_rdata  = 32'd0;
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'hCAFEF00D;
        @(posedge i_clk); #1;
        i_mem_ack = 1'b0;
        chk("late_ack_no_done", o_done, 32'd0);
        @(posedge i_clk); #1;
        chk("late_ack_no_done2", o_done, 32'd0);
        chk("late_ack_rdata", o_rdata, 32'd0);
        chk("late_ack_ready", o_ready, 32'd1);

        for (int n = 0; n < 60; n++) begin
            run_op(1'($urandom % 2), 3'($urandom % 8), 32'h80000000 | ($urandom % 64),
                   $urandom, $urandom, int'($urandom % 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Multi-cycle load/store unit between the execute stage (address = ALU result, store data = rs2) and a data-memory port with variable-latency request/acknowledge.
- Replaces the single-cycle combinational memory path.
- Formats byte/half/word accesses (lane select, write mask, sign/zero extension) and flags illegal or misaligned accesses.
- Provides a ready/done handshake so the core can stall on memory.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; the lane logic is fixed for 32.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; asynchronous, active-high.
- i_valid  in  1  request strobe from the execute stage.
- i_lden  in  1  load request.
- i_sten  in  1  store request.
- i_funct3  in  3  RV32 load/store funct3.
- i_addr  in  ADDR_W  byte address (ALU output).
- i_wdata  in  DATA_W  store data (rs2).
- o_ready  out  1  unit idle; a request can be accepted.
- o_done  out  1  one-cycle pulse: operation complete.
- o_err  out  1  valid with o_done; access was misaligned or illegal.
- o_rdata  out  DATA_W  formatted load result; valid with o_done.
- o_mem_req  out  1  memory request, held until acknowledged.
- o_mem_we  out  1  1 = write.
- o_mem_addr  out  ADDR_W  word-aligned address ({addr[31:2],2'b00}).
- o_mem_wdata  out  DATA_W  lane-shifted store data.
- o_mem_wmask  out  4  byte enables.
- i_mem_ack  in  1  memory acknowledge; read data valid in the same cycle.
- i_mem_rdata  in  DATA_W  memory read word.

Behaviour:
- Single clock i_clk. Reset i_rst is asynchronous, active-high.
- Reset values:
  - State = IDLE.
  - o_ready=1, o_done=0, o_err=0, o_mem_req=0, o_mem_we=0.
  - o_rdata, o_mem_addr, o_mem_wdata = 0; o_mem_wmask=0.
- States:
  - IDLE: o_ready=1. A request is accepted on i_valid & (i_lden ^ i_sten). The unit latches funct3, addr, wdata and the op.
    - Legal access → REQ.
    - Illegal access → RESP with err=1. No memory request is issued.
    - i_valid with neither or both of lden/sten → ignored; stay in IDLE.
  - REQ: o_mem_req=1; o_mem_addr/we/wdata/wmask are stable registered values.
    - On i_mem_ack: a load captures the formatted data into o_rdata → RESP.
    - Without ack: stay in REQ indefinitely. There is no timeout.
  - RESP: o_done=1 for exactly one cycle; o_err holds the latched error → IDLE. o_rdata holds its value until the next load completes.
- Latency:
  - Accept at cycle 0; o_mem_req high from cycle 1.
  - Ack at cycle k≥1 → o_done at cycle k+1.
  - With zero-wait memory (ack in the first REQ cycle), o_done appears at cycle 2.
  - Error path: o_done at cycle 1.
- Legality:
  - Loads: funct3 ∈ {0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU}.
  - Stores: funct3 ∈ {0 SB, 1 SH, 2 SW}.
  - Misaligned: half access with addr[0]=1; word access with addr[1:0]≠0.
- Store formatting, with o = addr[1:0]:
  - SB: wmask = 4'b0001<<o; wdata = {4{wdata[7:0]}}.
  - SH: wmask = 4'b0011<<o; wdata = {2{wdata[15:0]}}.
  - SW: wmask = 4'hF; wdata unchanged.
- Loads:
  - o_mem_wmask = 0.
  - Byte = rdata >> (8*o), take bits [7:0].
  - Half = rdata >> (8*o), take bits [15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Boundary rules:
  - i_valid while not in IDLE is ignored; the requester must hold the request until o_ready.
  - i_mem_ack outside REQ is ignored.
  - Async reset in REQ drops o_mem_req immediately. A late ack after reset is ignored.
  - x0 handling is not this unit's concern.

Decomposition:
- Shared defines file:
  - funct3 codes LB/LH/LW/LBU/LHU/SB/SH/SW.
  - State encoding LSU_IDLE=2'd0, LSU_REQ=2'd1, LSU_RESP=2'd2.
  - CPU_WIDTH.
- One combinational sub-module, lsu_fmt: legality check, write mask/data generation, and load extraction/extension. lsu_ctrl holds the FSM and registers.

Test Plan:
- SW addr 0x80000010, data 0xDEADBEEF, ack after 3 cycles → mem_req held 3 cycles, mem_addr 0x80000010, wmask 4'hF, wdata 0xDEADBEEF; o_done 1 cycle after ack, o_err=0.
- SB addr 0x80000013, data 0x000000A5, zero-wait ack → wmask 4'b1000, wdata 0xA5A5A5A5, mem_addr 0x80000010, o_done at cycle 2.
- LB addr 0x80000021, mem word 0x1234F678 → o_rdata 0xFFFFFFF6. LBU at the same address → 0x000000F6. LH at addr+1 → o_err=1 with no mem_req.
- LHU addr 0x80000022, word 0x8001ABCD → 0x00008001. LH → 0xFFFF8001. LW at addr 0x80000022 → o_err=1, o_done at cycle 1.
- Illegal load funct3=3, and i_valid with lden=sten=1 → error pulse for the first; second ignored (o_ready stays 1, no done).
- Assert i_rst during REQ → o_mem_req falls without waiting for a clock; o_ready=1. A subsequent ack produces no o_done.
